// File: rtl/muldiv_pkg.sv
// Shared constants and state encoding for the RV32M iterative multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational conditional two's-complement negate; with neg tied to the MSB it
// yields the absolute value.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         neg,
  output logic [W-1:0] fixed
);

  // Negate when requested, otherwise pass through.
  always_comb begin
    if (neg) begin
      fixed = ~value + W'(1);
    end else begin
      fixed = value;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit (start/busy/done, 32 iterations per op).
// Optional macro MULDIV_FAST_ZERO_EN: multiplies with a zero operand finish early.
import muldiv_pkg::*;

module mul_div_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic [4:0]      rdIn,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rdOut,
  output logic            rWriteOut
);

  localparam int            CW   = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  state_t              state_r, state_nx_s;
  logic [2:0]          op_r;
  logic [4:0]          rd_r;
  logic [XLEN-1:0]     opnd_r, result_r;
  logic [2*XLEN-1:0]   acc_r;
  logic [CW-1:0]       cnt_r;
  logic                neg_r, spec_r, busy_r, done_r, rwrite_r;

  logic                a_sgn_s, b_sgn_s, a_neg_s, b_neg_s, neg_s;
  logic                div0_s, ovf_s, zero_s, special_s;
  logic [XLEN-1:0]     a_abs_s, b_abs_s, spec_val_s;
  logic [XLEN:0]       sum_s, trial_s;
  logic [XLEN-1:0]     diff_s, rem_nx_s, fin_s;
  logic                ge_s;
  logic [2*XLEN-1:0]   step_s, fix_in_s, fix_out_s;

  muldiv_sign_fix #(.W(XLEN))   u_abs_a (.value(opA),      .neg(a_neg_s), .fixed(a_abs_s));
  muldiv_sign_fix #(.W(XLEN))   u_abs_b (.value(opB),      .neg(b_neg_s), .fixed(b_abs_s));
  muldiv_sign_fix #(.W(2*XLEN)) u_fix_r (.value(fix_in_s), .neg(neg_r),   .fixed(fix_out_s));

  // Operand signedness, result-sign flag and early-exit detection at accept.
  always_comb begin
    a_sgn_s = (funct3 == F3_MULH) | (funct3 == F3_MULHSU) | (funct3 == F3_DIV) | (funct3 == F3_REM);
    b_sgn_s = (funct3 == F3_MULH) | (funct3 == F3_DIV) | (funct3 == F3_REM);
    a_neg_s = a_sgn_s & opA[XLEN-1];
    b_neg_s = b_sgn_s & opB[XLEN-1];
    if (funct3 == F3_REM) begin
      neg_s = a_neg_s;
    end else begin
      neg_s = a_neg_s ^ b_neg_s;
    end
    div0_s = funct3[2] & (opB == {XLEN{1'b0}});
    ovf_s  = ((funct3 == F3_DIV) | (funct3 == F3_REM)) & (opA == INT_MIN) & (opB == ALL_ONES);
`ifdef MULDIV_FAST_ZERO_EN
    zero_s = ~funct3[2] & ((opA == {XLEN{1'b0}}) | (opB == {XLEN{1'b0}}));
`else
    zero_s = 1'b0;
`endif
    special_s = div0_s | ovf_s | zero_s;
    if (div0_s) begin
      spec_val_s = funct3[1] ? opA : ALL_ONES;
    end else if (ovf_s) begin
      spec_val_s = funct3[1] ? {XLEN{1'b0}} : INT_MIN;
    end else begin
      spec_val_s = {XLEN{1'b0}};
    end
  end

  // One shift-add or restoring shift-subtract step, plus final sign correction and select.
  always_comb begin
    sum_s    = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
    trial_s  = acc_r[2*XLEN-1:XLEN-1];
    ge_s     = (trial_s >= {1'b0, opnd_r});
    diff_s   = trial_s[XLEN-1:0] - opnd_r;
    if (ge_s) begin
      rem_nx_s = diff_s;
    end else begin
      rem_nx_s = trial_s[XLEN-1:0];
    end
    if (op_r[2]) begin
      step_s = {rem_nx_s, acc_r[XLEN-2:0], ge_s};
    end else begin
      step_s = {sum_s, acc_r[XLEN-1:1]};
    end
    // Divide keeps remainder in the upper half and quotient in the lower half.
    if (!op_r[2]) begin
      fix_in_s = acc_r;
    end else if (op_r[1]) begin
      fix_in_s = {{XLEN{1'b0}}, acc_r[2*XLEN-1:XLEN]};
    end else begin
      fix_in_s = {{XLEN{1'b0}}, acc_r[XLEN-1:0]};
    end
    if (spec_r) begin
      fin_s = acc_r[XLEN-1:0];
    end else if (op_r == F3_MUL) begin
      fin_s = fix_out_s[XLEN-1:0];
    end else if (!op_r[2]) begin
      fin_s = fix_out_s[2*XLEN-1:XLEN];
    end else begin
      fin_s = fix_out_s[XLEN-1:0];
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx_s = special_s ? ST_FINISH : ST_CALC;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (cnt_r == LAST) begin
          state_nx_s = ST_FINISH;
        end else begin
          state_nx_s = ST_CALC;
        end
      end
      ST_FINISH: state_nx_s = ST_IDLE;
      default:   state_nx_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r     <= 3'd0;
      rd_r     <= 5'd0;
      opnd_r   <= {XLEN{1'b0}};
      acc_r    <= {(2*XLEN){1'b0}};
      cnt_r    <= {CW{1'b0}};
      neg_r    <= 1'b0;
      spec_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      rwrite_r <= 1'b0;
      result_r <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r   <= 1'b0;
          rwrite_r <= 1'b0;
          if (start) begin
            op_r   <= funct3;
            rd_r   <= rdIn;
            cnt_r  <= {CW{1'b0}};
            neg_r  <= neg_s;
            spec_r <= special_s;
            busy_r <= 1'b1;
            if (special_s) begin
              acc_r <= {{XLEN{1'b0}}, spec_val_s};
            end else if (funct3[2]) begin
              opnd_r <= b_abs_s;
              acc_r  <= {{XLEN{1'b0}}, a_abs_s};
            end else begin
              opnd_r <= a_abs_s;
              acc_r  <= {{XLEN{1'b0}}, b_abs_s};
            end
          end
        end
        ST_CALC: begin
          acc_r <= step_s;
          cnt_r <= cnt_r + CW'(1);
        end
        ST_FINISH: begin
          result_r <= fin_s;
          done_r   <= 1'b1;
          rwrite_r <= (rd_r != 5'd0);
          busy_r   <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign result    = result_r;
  assign rdOut     = rd_r;
  assign rWriteOut = rwrite_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus randomized ops against
// an arithmetic reference model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  funct3;
  logic [31:0] opA, opB;
  logic [4:0]  rdIn;
  logic        busy, done, rWriteOut;
  logic [31:0] result;
  logic [4:0]  rdOut;

  int n_cmp = 0;
  int n_bad = 0;

  mul_div_unit #(.XLEN(32), .ITER(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .opA(opA), .opB(opB), .rdIn(rdIn), .busy(busy), .done(done),
    .result(result), .rdOut(rdOut), .rWriteOut(rWriteOut)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f)
      3'd0: begin t = ua * ub; return t[31:0]; end
      3'd1: begin t = sa * sb; return t[63:32]; end
      3'd2: begin t = sa * ub; return t[63:32]; end
      3'd3: begin t = ua * ub; return t[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        t = sa / sb;
        return t[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        t = ua / ub;
        return t[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        t = sa % sb;
        return t[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        t = ua % ub;
        return t[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bit early;
    early = (f[2] && b == 32'd0) ||
            ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef MULDIV_FAST_ZERO_EN
    early = early || (!f[2] && (a == 32'd0 || b == 32'd0));
`endif
    return early ? 1 : 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      4: return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  // Waits for done after the accept edge; n counts edges from accept.
  task automatic wait_done(inout int n);
    while (!done && n < 100) tick_count(n);
  endtask

  task automatic tick_count(inout int n);
    tick();
    n++;
  endtask

  // Issues one op immediately (caller sits just after an edge) and checks it fully.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input string tag);
    int n = 0;
    funct3 = f; opA = a; opB = b; rdIn = rd; start = 1'b1;
    tick();
    start = 1'b0;
    check_eq({tag, "/busy"}, {31'd0, busy}, 32'd1);
    check_eq({tag, "/done_low"}, {31'd0, done}, 32'd0);
    wait_done(n);
    check_eq({tag, "/latency"}, n, ref_latency(f, a, b));
    check_eq({tag, "/result"}, result, ref_result(f, a, b));
    check_eq({tag, "/rdOut"}, {27'd0, rdOut}, {27'd0, rd});
    check_eq({tag, "/rWrite"}, {31'd0, rWriteOut}, {31'd0, (rd != 5'd0)});
    check_eq({tag, "/busy_clr"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic count_done(input int cycles, input string tag);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done) seen++;
    end
    check_eq(tag, seen, 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; funct3 = 3'd0; opA = 32'd0; opB = 32'd0; rdIn = 5'd0;
    repeat (3) tick();
    reset = 1'b0;
    check_eq("rst/busy", {31'd0, busy}, 32'd0);
    check_eq("rst/done", {31'd0, done}, 32'd0);
    check_eq("rst/result", result, 32'd0);
    check_eq("rst/rdOut", {27'd0, rdOut}, 32'd0);
    check_eq("rst/rWrite", {31'd0, rWriteOut}, 32'd0);
    tick();

    // Directed cases, issued back-to-back on each done cycle.
    run_op(3'd0, 32'd7, 32'd252, 5'd5, "mul");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, "mulh");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, "mulhu");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, "div");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, "rem");
    run_op(3'd5, 32'h0000_1234, 32'd0, 5'd7, "divu0");
    run_op(3'd7, 32'h0000_1234, 32'd0, 5'd8, "remu0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, "divovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, "removf");
    run_op(3'd0, 32'd0, 32'd1234, 5'd11, "mulzero");
    run_op(3'd0, 32'd3, 32'd5, 5'd0, "rd0");

    // Reset during iteration 10 discards the operation.
    funct3 = 3'd4; opA = 32'd1000; opB = 32'd7; rdIn = 5'd12; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("midrst/busy", {31'd0, busy}, 32'd0);
    check_eq("midrst/done", {31'd0, done}, 32'd0);
    check_eq("midrst/result", result, 32'd0);
    count_done(40, "midrst/no_done");
    run_op(3'd5, 32'd1000, 32'd7, 5'd13, "after_rst");

    // start while busy must be ignored.
    funct3 = 3'd0; opA = 32'd7; opB = 32'd252; rdIn = 5'd5; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    repeat (5) tick_count(n);
    funct3 = 3'd5; opA = 32'd100; opB = 32'd3; rdIn = 5'd9; start = 1'b1;
    tick_count(n);
    start = 1'b0;
    repeat (10) tick_count(n);
    start = 1'b1;
    tick_count(n);
    start = 1'b0;
    wait_done(n);
    check_eq("busystart/latency", n, 32'd33);
    check_eq("busystart/result", result, 32'd1764);
    check_eq("busystart/rdOut", {27'd0, rdOut}, 32'd5);
    count_done(40, "busystart/no_extra");

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom_range(0, 31)),
             $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
